// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// The MEM_ARB_RR_EN macro (see mem_arbiter.sv) selects round-robin arbitration.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Address bit that selects the slower UART space.
    localparam int UART_BIT = 29;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between the fetch and load/store requesters.
// With MEM_ARB_RR_EN defined, simultaneous requests alternate using rr_last.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t rr_last,
`endif
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    always_comb begin
        gnt_valid = if_req | mem_req;
        gnt_owner = mem_req ? OWN_MEM : OWN_IF;
`ifdef MEM_ARB_RR_EN
        // Only a tie consults the pointer; a lone requester always wins.
        if (if_req && mem_req) begin
            gnt_owner = (rr_last == OWN_MEM) ? OWN_IF : OWN_MEM;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the MMU port between instruction fetch and load/store with IDLE/ACCESS/DONE sequencing.
// Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests (default: MEM over IF).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_WAIT  = 1,
    parameter int UART_WAIT = 2,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_byte,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        stall,
    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_bytemode,
    input  logic [31:0] mmu_rdata
);

    localparam logic [CNT_W-1:0] RAM_LOAD  = CNT_W'(RAM_WAIT - 1);
    localparam logic [CNT_W-1:0] UART_LOAD = CNT_W'(UART_WAIT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    owner_t             owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               byte_q, byte_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               if_ready_q, if_ready_d;
    logic               mem_ready_q, mem_ready_d;
    logic               mmu_read_q, mmu_read_d;
    logic               mmu_write_q, mmu_write_d;

    logic               gnt_valid;
    owner_t             gnt_owner;

`ifdef MEM_ARB_RR_EN
    owner_t             rr_q, rr_d;
`endif

    mem_arb_grant u_grant (
        .if_req    (if_req),
        .mem_req   (mem_req),
`ifdef MEM_ARB_RR_EN
        .rr_last   (rr_q),
`endif
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        byte_d      = byte_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        mmu_read_d  = 1'b0;
        mmu_write_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    if (gnt_owner == OWN_MEM) begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_we;
                        byte_d  = mem_byte;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = 32'd0;
                        we_d    = 1'b0;
                        byte_d  = 1'b0;
                    end
                    cnt_d       = addr_d[UART_BIT] ? UART_LOAD : RAM_LOAD;
                    mmu_read_d  = ~we_d;
                    mmu_write_d = we_d;
                    state_d     = ACCESS;
`ifdef MEM_ARB_RR_EN
                    rr_d        = gnt_owner;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mmu_read_d  = ~we_q;
                    mmu_write_d = we_q;
                end else begin
                    // Last strobe cycle: mmu_rdata is valid now, stores leave rdata alone.
                    if (!we_q) begin
                        if (owner_q == OWN_MEM) mem_rdata_d = mmu_rdata;
                        else                    if_rdata_d  = mmu_rdata;
                    end
                    if (owner_q == OWN_MEM) mem_ready_d = 1'b1;
                    else                    if_ready_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            mmu_read_q  <= 1'b0;
            mmu_write_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q        <= OWN_MEM;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            mmu_read_q  <= mmu_read_d;
            mmu_write_q <= mmu_write_d;
`ifdef MEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ready    = mem_ready_q;
    assign mmu_read     = mmu_read_q;
    assign mmu_write    = mmu_write_q;
    assign mmu_addr     = addr_q;
    assign mmu_wdata    = wdata_q;
    assign mmu_bytemode = byte_q;
    assign stall        = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a timestamp-based transaction model checked every cycle,
// plus literal latency/data expectations from hand-worked scenarios.
module tb_mem_arbiter;

    localparam int RAM_WAIT  = 1;
    localparam int UART_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, mem_byte;
    logic [31:0] if_addr, mem_addr, mem_wdata, mmu_rdata;
    logic [31:0] if_rdata, mem_rdata, mmu_addr, mmu_wdata;
    logic        if_ready, mem_ready, stall, mmu_read, mmu_write, mmu_bytemode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_WAIT(RAM_WAIT), .UART_WAIT(UART_WAIT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_byte     (mem_byte),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .stall        (stall),
        .mmu_read     (mmu_read),
        .mmu_write    (mmu_write),
        .mmu_addr     (mmu_addr),
        .mmu_wdata    (mmu_wdata),
        .mmu_bytemode (mmu_bytemode),
        .mmu_rdata    (mmu_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a granted request occupies edges ts .. ts+wait+1;
    // the strobe is live for `wait` cycles and ready follows in the next one.
    int          k = 0;
    bit          model_ok = 0;
    bit          m_busy, m_owner_mem, m_we, m_byte, m_last_mem;
    int          m_ts, m_wait;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;

    always @(posedge clk) begin
        k++;
        if (rst) begin
            m_busy = 0; m_owner_mem = 0; m_we = 0; m_byte = 0; m_last_mem = 1;
            m_addr = 0; m_wdata = 0; m_if_rd = 0; m_mem_rd = 0;
            model_ok = 1;
        end else if (m_busy) begin
            if (k == m_ts + m_wait && !m_we) begin
                if (m_owner_mem) m_mem_rd = mmu_rdata;
                else             m_if_rd  = mmu_rdata;
            end
            if (k == m_ts + m_wait + 1) m_busy = 0;
        end else if (if_req || mem_req) begin
`ifdef MEM_ARB_RR_EN
            m_owner_mem = (if_req && mem_req) ? !m_last_mem : mem_req;
`else
            m_owner_mem = mem_req;
`endif
            m_last_mem = m_owner_mem;
            m_addr  = m_owner_mem ? mem_addr  : if_addr;
            m_wdata = m_owner_mem ? mem_wdata : 32'd0;
            m_we    = m_owner_mem ? mem_we    : 1'b0;
            m_byte  = m_owner_mem ? mem_byte  : 1'b0;
            m_wait  = m_addr[29] ? UART_WAIT : RAM_WAIT;
            m_ts    = k;
            m_busy  = 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit acc, rdy, e_ifr, e_memr;
        if (model_ok) begin
            acc    = m_busy && (k < m_ts + m_wait);
            rdy    = m_busy && (k == m_ts + m_wait);
            e_ifr  = rdy && !m_owner_mem;
            e_memr = rdy && m_owner_mem;
            chk("mmu_read",     {31'd0, mmu_read},     {31'd0, acc && !m_we});
            chk("mmu_write",    {31'd0, mmu_write},    {31'd0, acc && m_we});
            chk("mmu_addr",     mmu_addr,              m_addr);
            chk("mmu_wdata",    mmu_wdata,             m_wdata);
            chk("mmu_bytemode", {31'd0, mmu_bytemode}, {31'd0, m_byte});
            chk("if_ready",     {31'd0, if_ready},     {31'd0, e_ifr});
            chk("mem_ready",    {31'd0, mem_ready},    {31'd0, e_memr});
            chk("if_rdata",     if_rdata,              m_if_rd);
            chk("mem_rdata",    mem_rdata,             m_mem_rd);
            chk("stall",        {31'd0, stall},
                {31'd0, (if_req && !e_ifr) || (mem_req && !e_memr)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counts cycles (negedges) from the request until the ready pulse, bounded.
    task automatic wait_ready(input string name, input bit want_mem, output int lat);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (want_mem ? mem_ready : if_ready) break;
        end
        chk({name, "_ready_seen"}, {31'd0, (want_mem ? mem_ready : if_ready)}, 32'd1);
    endtask

    int lat;
    bit first_mem;

    initial begin
        rst = 1; if_req = 0; mem_req = 0; mem_we = 0; mem_byte = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mmu_rdata = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_mmu_addr", mmu_addr, 32'd0);

        // IF-only fetch from SRAM
        tick();
        if_addr = 32'h8000_0004; mmu_rdata = 32'h3C01_1234; if_req = 1;
        wait_ready("t1", 0, lat);
        chk("t1_latency", lat, 3);
        chk("t1_if_rdata", if_rdata, 32'h3C01_1234);
        $display("txn IF read  addr=80000004 lat=%0d rdata=%08h", lat, if_rdata);
        tick(); if_req = 0;

        // UART load (two strobe cycles)
        tick();
        mem_addr = 32'hBFD0_03F8; mem_we = 0; mem_byte = 0; mmu_rdata = 32'h0000_0041; mem_req = 1;
        wait_ready("t2", 1, lat);
        chk("t2_latency", lat, 4);
        chk("t2_mem_rdata", mem_rdata, 32'h0000_0041);
        $display("txn MEM load addr=bfd003f8 lat=%0d rdata=%08h", lat, mem_rdata);
        tick(); mem_req = 0;

        // Byte store leaves mem_rdata alone
        tick();
        mem_addr = 32'h8000_0003; mem_wdata = 32'h0000_00AB; mem_we = 1; mem_byte = 1;
        mmu_rdata = 32'h5555_5555; mem_req = 1;
        @(negedge clk); @(negedge clk);
        chk("t3_bytemode", {31'd0, mmu_bytemode}, 32'd1);
        chk("t3_mmu_write", {31'd0, mmu_write}, 32'd1);
        wait_ready("t3", 1, lat);
        chk("t3_latency", lat + 2, 3);
        chk("t3_mem_rdata_kept", mem_rdata, 32'h0000_0041);
        $display("txn MEM byte store addr=80000003 wdata=000000ab lat=%0d", lat + 2);
        tick(); mem_req = 0; mem_we = 0; mem_byte = 0;

        // Simultaneous requests straight after reset (RR pointer = MEM)
        tick(); rst = 1;
        tick(); rst = 0;
        if_addr = 32'h8000_0000; mmu_rdata = 32'h1111_2222;
        mem_addr = 32'h8040_0010; mem_wdata = 32'hDEAD_BEEF; mem_we = 1;
        if_req = 1; mem_req = 1;
`ifdef MEM_ARB_RR_EN
        first_mem = 0;
`else
        first_mem = 1;
`endif
        @(negedge clk); @(negedge clk);
        chk("t4_first_addr", mmu_addr, first_mem ? 32'h8040_0010 : 32'h8000_0000);
        wait_ready("t4a", first_mem, lat);
        chk("t4a_latency", lat + 2, 3);
        $display("txn simultaneous first=%s lat=%0d", first_mem ? "MEM" : "IF", lat + 2);
        tick();
        if (first_mem) mem_req = 0; else if_req = 0;
        wait_ready("t4b", !first_mem, lat);
        chk("t4b_latency", lat, 3);
        chk("t4_if_rdata", if_rdata, 32'h1111_2222);
        $display("txn simultaneous second=%s lat=%0d", first_mem ? "IF" : "MEM", lat);
        tick(); if_req = 0; mem_req = 0; mem_we = 0;

        // Reset in the final UART strobe cycle, request held, then restart
        tick();
        mem_addr = 32'hBFD0_03F8; mmu_rdata = 32'h0000_0077; mem_req = 1;
        @(negedge clk); @(negedge clk);
        chk("t5_mmu_read_before", {31'd0, mmu_read}, 32'd1);
        @(posedge clk); #2 rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        chk("t5_mmu_read_after_rst", {31'd0, mmu_read}, 32'd0);
        chk("t5_no_ready", {31'd0, mem_ready}, 32'd0);
        chk("t5_rdata_cleared", mem_rdata, 32'd0);
        wait_ready("t5", 1, lat);
        chk("t5_restart_latency", lat + 1, 4);
        chk("t5_mem_rdata", mem_rdata, 32'h0000_0077);
        $display("txn MEM load after reset lat=%0d rdata=%08h", lat + 1, mem_rdata);
        tick(); mem_req = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single MMU memory port (base/ext SRAM plus UART) between the instruction-fetch (IF) requester and the load/store (MEM) requester.
- Latches the winning request and drives the MMU control, address and data inputs for a fixed number of wait cycles.
- Captures the read data and returns it with a one-cycle ready pulse.
- Generates the pipeline stall. Sits between the CPU pipeline and the MMU.

Parameters:
- RAM_WAIT, 1, cycles the MMU read/write is held for an SRAM access (>=1).
- UART_WAIT, 2, cycles held when the target address has bit 29 set (UART space) (>=1).
- CNT_W, 4, width of the wait counter; must hold max(RAM_WAIT, UART_WAIT)-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch address (word read, bytemode 0)
- if_rdata  out  32  fetched instruction, registered
- if_ready  out  1  one-cycle pulse: if_rdata valid
- mem_req  in  1  load/store request; held high until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_byte  in  1  byte access (LB/SB)
- mem_rdata  out  32  load result, registered
- mem_ready  out  1  one-cycle pulse: access complete
- stall  out  1  pipeline stall
- mmu_read  out  1  to MMU if_read
- mmu_write  out  1  to MMU if_write
- mmu_addr  out  32  to MMU addr
- mmu_wdata  out  32  to MMU input_data
- mmu_bytemode  out  1  to MMU bytemode
- mmu_rdata  in  32  from MMU output_data

Behaviour:
- The reset value of every output is 0.
- Reset also forces: state IDLE, counter 0, owner register 0, RR pointer to MEM.
- Reset mid-access aborts immediately. mmu_read/mmu_write are 0 in the cycle after reset is sampled. No ready pulse is issued for the aborted request.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - If mem_req or if_req is high, pick the winner. MEM beats IF (fixed priority).
  - Latch into registers: addr, wdata, we (IF: 0), byte (IF: 0) and owner.
  - Load the counter with (addr[29] ? UART_WAIT : RAM_WAIT) - 1, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive mmu_addr, mmu_wdata and mmu_bytemode from the latched registers.
  - mmu_read = ~we_r and mmu_write = we_r.
  - While the counter is non-zero, decrement it.
  - When the counter is 0: on a read, capture mmu_rdata into the owner's rdata register; go to DONE.
- DONE:
  - mmu_read = mmu_write = 0.
  - Assert the owner's ready for exactly one cycle, then go to IDLE.
  - Requests are ignored in this cycle.
- Outside ACCESS: mmu_read = mmu_write = 0; mmu_addr, mmu_wdata and mmu_bytemode hold their last latched values.
- Latency from request sampled in IDLE to ready: WAIT+2 cycles (RAM_WAIT=1 gives 3).
- Back-to-back requests are re-arbitrated in the IDLE cycle following DONE.
- A store leaves mem_rdata unchanged.
- The rdata registers hold their value until the next completed read for that owner.
- stall = (if_req & ~if_ready) | (mem_req & ~mem_ready), combinational.
- A request dropped before its ready pulse: behaviour is undefined. Requesters must hold req, addr and data stable until ready.
- Both requests in the same IDLE cycle: MEM is served first; IF waits one full transaction plus one IDLE cycle.
- Counter arithmetic is unsigned CNT_W bits. It never underflows; the decrement is gated at 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer records the last owner. On a simultaneous request, the non-last owner wins. The pointer updates on each IDLE->ACCESS transition. A single requester always wins regardless of the pointer.
- Undefined: fixed MEM-over-IF priority; the pointer logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - owner encoding (OWN_IF=0, OWN_MEM=1);
  - the UART select bit index constant (29).
- One natural sub-module, mem_arb_grant: combinational winner selection from the two requests plus the RR pointer (the pointer is only used under MEM_ARB_RR_EN).

Test Plan:
- IF only: if_addr=0x80000004, mmu_rdata=0x3C011234, RAM_WAIT=1 -> mmu_read high 1 cycle, if_ready pulses 3 cycles after request, if_rdata=0x3C011234, stall high for the first 2 cycles and low in the ready cycle.
- Simultaneous requests: IF read 0x80000000 plus MEM store 0x80400010 data 0xDEADBEEF -> MEM served first (mmu_write=1, mmu_addr=0x80400010, mmu_wdata=0xDEADBEEF), then IF; with MEM_ARB_RR_EN and last owner=MEM, IF is served first.
- UART load from 0xBFD003F8 with UART_WAIT=2 -> mmu_read high 2 consecutive cycles, mem_ready 4 cycles after request, mem_rdata=mmu_rdata.
- Byte store: mem_byte=1, addr 0x80000003, wdata 0x000000AB -> mmu_bytemode=1, mmu_write=1 for 1 cycle, mem_rdata unchanged.
- rst asserted during ACCESS -> next cycle state IDLE, mmu_read=mmu_write=0, no ready pulse; a held request restarts and completes normally.
